// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit holding the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign fix-up.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic               is_div_q, is_div_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, dividend;

  // Signed ops (op[0]=0) work on magnitudes; signs are reapplied in FIX.
  assign sign_a = ~op[0] & A[WIDTH-1];
  assign sign_b = ~op[0] & B[WIDTH-1];
  assign a_mag  = sign_a ? -A : A;
  assign b_mag  = sign_b ? -B : B;

  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign shifted  = {rem_q, acc_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, b_q};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? -rem_q : rem_q;
  assign dividend = neg_a_q ? -a_q : a_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              a_d      = a_mag;
              b_d      = b_mag;
              neg_a_d  = sign_a;
              neg_b_d  = sign_b;
              is_div_d = op[1];
              rem_d    = '0;
              acc_d    = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              cnt_d    = CW'(WIDTH - 1);
              state_d  = CALC;
            end
            3'b100:  hi_d = A;
            3'b101:  lo_d = A;
            default: ;
          endcase
        end
      end

      CALC: begin
        // Divide keeps the quotient in the low half of acc; multiply uses all of it.
        if (is_div_q) begin
          rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH]};
        end else if (acc_q[0]) begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end

      FIX: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_q == '0) begin
          hi_d = dividend;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vectors, timing, interference,
// reset abort and randomized ops against an arithmetic reference model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_hi, exp_lo;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural rules.
  function automatic void ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sp;
    logic [63:0] up;
    h = '0;
    l = '0;
    case (o)
      3'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        h = sp[63:32];
        l = sp[31:0];
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        h = up[63:32];
        l = up[31:0];
      end
      3'd2: begin
        if (b == 0) begin h = a; l = '1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 0; l = a; end
        else begin l = $signed(a) / $signed(b); h = $signed(a) % $signed(b); end
      end
      3'd3: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge; leaves the bench at the negedge of cycle 1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
  endtask

  // Returns the cycle number (1 = first cycle after the start edge) of done.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_multu_timing();
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int cyc = 1; cyc <= 33; cyc++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
        n_fail++;
        $display("[TB] FAIL multu_busy cyc %0d got busy=%b done=%b hi=%h lo=%h want 1 0 0 0", cyc, busy, done, hi, lo);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      n_fail++;
      $display("[TB] FAIL multu_result got done=%b busy=%b hi=%h lo=%h want 1 0 fffffffe 00000001", done, busy, hi, lo);
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL multu_done_pulse got %b want 0", done); end
  endtask

  logic [2:0]  dir_op [5] = '{3'd0, 3'd3, 3'd2, 3'd2, 3'd3};
  logic [31:0] dir_a  [5] = '{32'hFFFFFFFD, 32'd100, 32'hFFFFFFF9, 32'h80000000, 32'h12345678};
  logic [31:0] dir_b  [5] = '{32'd7, 32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
  logic [31:0] dir_hi [5] = '{32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'h0, 32'h12345678};
  logic [31:0] dir_lo [5] = '{32'hFFFFFFEB, 32'd14, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};

  task automatic test_directed();
    int cyc;
    for (int i = 0; i < 5; i++) begin
      issue(dir_op[i], dir_a[i], dir_b[i]);
      wait_done(cyc);
      n_cmp++;
      if (cyc != 34 || hi !== dir_hi[i] || lo !== dir_lo[i]) begin
        n_fail++;
        $display("[TB] FAIL directed_%0d got cyc=%0d hi=%h lo=%h want 34 %h %h", i, cyc, hi, lo, dir_hi[i], dir_lo[i]);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] old_lo;
    @(negedge clk);
    old_lo = lo;
    issue(3'd4, 32'hCAFEF00D, 32'h0);
    n_cmp++;
    if (hi !== 32'hCAFEF00D || lo !== old_lo || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mthi got hi=%h lo=%h busy=%b done=%b want cafef00d %h 0 0", hi, lo, busy, done, old_lo);
    end
    issue(3'd5, 32'h0BADBEEF, 32'h0);
    n_cmp++;
    if (lo !== 32'h0BADBEEF || hi !== 32'hCAFEF00D || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mtlo got hi=%h lo=%h busy=%b want cafef00d 0badbeef 0", hi, lo, busy);
    end
    issue(3'd6, 32'h11111111, 32'h22222222);
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'hCAFEF00D || lo !== 32'h0BADBEEF || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL op_none got hi=%h lo=%h busy=%b done=%b want cafef00d 0badbeef 0 0", hi, lo, busy, done);
    end
  endtask

  task automatic test_interference();
    int c;
    issue(3'd4, 32'h1111, 32'h0);
    issue(3'd5, 32'h2222, 32'h0);
    issue(3'd1, 32'd3, 32'd5);
    for (int cyc = 1; cyc <= 34; cyc++) begin
      start = 1'b0;
      if (cyc == 6) begin
        n_cmp++;
        if (lo !== 32'h2222 || busy !== 1'b1) begin
          n_fail++; $display("[TB] FAIL mtlo_ignored got lo=%h busy=%b want 2222 1", lo, busy);
        end
      end
      if (cyc == 11) begin
        n_cmp++;
        if (hi !== 32'h1111 || lo !== 32'h2222) begin
          n_fail++; $display("[TB] FAIL hold_during_calc got hi=%h lo=%h want 1111 2222", hi, lo);
        end
      end
      if (cyc == 5)  begin start = 1'b1; op = 3'd5; A = 32'hDEAD; end
      if (cyc == 10) begin start = 1'b1; op = 3'd0; A = 32'd7; B = 32'd9; end
      if (cyc == 34) begin
        n_cmp++;
        if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'd15) begin
          n_fail++; $display("[TB] FAIL interfere_result got done=%b hi=%h lo=%h want 1 0 f", done, hi, lo);
        end
        start = 1'b1; op = 3'd3; A = 32'd1000; B = 32'd10;
      end
      if (cyc < 34) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(c);
    n_cmp++;
    if (c != 34 || hi !== 32'h0 || lo !== 32'd100) begin
      n_fail++; $display("[TB] FAIL done_cycle_start got cyc=%0d hi=%h lo=%h want 34 0 64", c, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    issue(3'd4, 32'hAAAA5555, 32'h0);
    issue(3'd5, 32'h5555AAAA, 32'h0);
    issue(3'd3, 32'd100, 32'd7);
    for (int cyc = 1; cyc < 10; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_done) begin n_fail++; $display("[TB] FAIL reset_abort got activity=1 want 0"); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, eh, el;
    int cyc, pick;
    pulse_reset();
    exp_hi = 0; exp_lo = 0;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 5)); a = $urandom; b = $urandom;
      pick = $urandom_range(0, 7);
      if (pick == 0) b = 0;
      if (pick == 1) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
      if (pick == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (o < 3'd4) begin
        ref_mdu(o, a, b, eh, el);
        issue(o, a, b);
        wait_done(cyc);
        exp_hi = eh; exp_lo = el;
        n_cmp++;
        if (cyc != 34 || hi !== exp_hi || lo !== exp_lo) begin
          n_fail++;
          $display("[TB] FAIL random_%0d op=%0d a=%h b=%h got cyc=%0d hi=%h lo=%h want 34 %h %h", i, o, a, b, cyc, hi, lo, exp_hi, exp_lo);
        end
      end else begin
        if (o == 3'd4) exp_hi = a; else exp_lo = a;
        issue(o, a, b);
        n_cmp++;
        if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL random_move_%0d got hi=%h lo=%h busy=%b want %h %h 0", i, hi, lo, busy, exp_hi, exp_lo);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] a, b, eh, el;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      o = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom_range(0, 9);
      ref_mdu(o, a, b, eh, el);
      issue(o, a, b);
      wait_done(cyc);
      n_cmp++;
      if (cyc != 34 || hi !== eh || lo !== el) begin
        n_fail++;
        $display("[TB] FAIL back_to_back_%0d op=%0d got cyc=%0d hi=%h lo=%h want 34 %h %h", i, o, cyc, hi, lo, eh, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_directed();
    test_mthi_mtlo();
    test_interference();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
